// File: rtl/uart_wb_rx_streamer.sv
// Wishbone master that programs a 16550 UART, then polls LSR and streams each
// received byte (with its LSR error flags) out on a valid/ready interface.
module uart_wb_rx_streamer #(
  parameter logic [15:0] DIVISOR  = 16'd2,
  parameter logic [7:0]  LCR_VAL  = 8'h1B,
  parameter int          POLL_GAP = 4
) (
  input  logic        clk,
  input  logic        wb_rst_i,
  output logic [4:0]  wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_we_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  output logic [7:0]  m_data,
  output logic [3:0]  m_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        cfg_done
);

  typedef enum logic [2:0] {
    CFG_DLAB, CFG_DL1, CFG_DL2, CFG_LCR, POLL_WAIT, POLL_LSR, READ_RBR, OUT_HOLD
  } state_t;

  // A gap of 0 behaves as 1; the counter is 8 bits so the gap saturates at 255.
  localparam int         GAP_EFF  = (POLL_GAP < 1) ? 1 : ((POLL_GAP > 255) ? 255 : POLL_GAP);
  localparam logic [7:0] GAP_LAST = 8'(GAP_EFF - 1);

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [4:0]  nxt_adr;
  logic [31:0] nxt_dat;
  logic [3:0]  nxt_sel;
  logic        nxt_we;
  logic        unused_dat;

  assign unused_dat = ^{wb_dat_i[31:16], wb_dat_i[15:13]};

  // Bus request the current state would launch.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves it unassigned (no latch).
    nxt_adr = '0;
    nxt_dat = '0;
    nxt_sel = '0;
    nxt_we  = 1'b0;
    case (state)
      CFG_DLAB: begin
        nxt_adr = 5'd3;
        nxt_sel = 4'b1000;
        nxt_dat = {1'b1, LCR_VAL[6:0], 24'h0};
        nxt_we  = 1'b1;
      end
      CFG_DL1: begin
        nxt_adr = 5'd0;
        nxt_sel = 4'b0001;
        nxt_dat = {24'h0, DIVISOR[7:0]};
        nxt_we  = 1'b1;
      end
      CFG_DL2: begin
        nxt_adr = 5'd1;
        nxt_sel = 4'b0010;
        nxt_dat = {16'h0, DIVISOR[15:8], 8'h0};
        nxt_we  = 1'b1;
      end
      CFG_LCR: begin
        nxt_adr = 5'd3;
        nxt_sel = 4'b1000;
        nxt_dat = {1'b0, LCR_VAL[6:0], 24'h0};
        nxt_we  = 1'b1;
      end
      POLL_LSR: begin
        nxt_adr = 5'd5;
        nxt_sel = 4'b0010;
      end
      READ_RBR: begin
        nxt_adr = 5'd0;
        nxt_sel = 4'b0001;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= CFG_DLAB;
      gap_cnt  <= '0;
      wb_adr_o <= '0;
      wb_dat_o <= '0;
      wb_sel_o <= '0;
      wb_we_o  <= 1'b0;
      wb_cyc_o <= 1'b0;
      wb_stb_o <= 1'b0;
      m_data   <= '0;
      m_err    <= '0;
      m_valid  <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
      case (state)
        POLL_WAIT: begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= POLL_LSR;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        OUT_HOLD: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            state   <= POLL_LSR;
          end
        end
        default: begin
          // Launch when idle; the cycle after an ack is always idle, separating transfers.
          if (!wb_cyc_o) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= nxt_we;
            wb_adr_o <= nxt_adr;
            wb_dat_o <= nxt_dat;
            wb_sel_o <= nxt_sel;
          end else if (wb_ack_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            case (state)
              CFG_DLAB: state <= CFG_DL1;
              CFG_DL1:  state <= CFG_DL2;
              CFG_DL2:  state <= CFG_LCR;
              CFG_LCR: begin
                cfg_done <= 1'b1;
                state    <= POLL_WAIT;
              end
              POLL_LSR: begin
                if (wb_dat_i[8]) begin
                  m_err <= wb_dat_i[12:9];
                  state <= READ_RBR;
                end else begin
                  state <= POLL_WAIT;
                end
              end
              READ_RBR: begin
                m_data  <= wb_dat_i[7:0];
                m_valid <= 1'b1;
                state   <= OUT_HOLD;
              end
              default: state <= CFG_DLAB;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_rx_streamer.sv
// Self-checking bench: a 16550-like Wishbone slave with an RX byte queue and a
// scoreboard of expected configuration writes and stream beats.
module tb_uart_wb_rx_streamer;

  logic        clk = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic [4:0]  wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;
  logic [7:0]  m_data;
  logic [3:0]  m_err;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        cfg_done;

  uart_wb_rx_streamer dut (
    .clk(clk), .wb_rst_i(wb_rst_i),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .m_data(m_data), .m_err(m_err), .m_valid(m_valid), .m_ready(m_ready), .cfg_done(cfg_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] lsr;
    logic [7:0] data;
  } rx_t;

  rx_t         rx_q[$];
  logic [11:0] exp_beats[$];
  logic [40:0] exp_wr[$];

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {6'b0, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
            m_data, m_err, m_valid, cfg_done};
  endfunction

  int cyc_n = 0;
  always @(posedge clk) cyc_n++;

  // Wishbone slave: acks after ack_delay extra cycles, checks request stability.
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rbr_t = 0;
  logic        unstable = 1'b0;
  logic [41:0] cap = '0;

  task automatic serve();
    check("xfer_stable", unstable, 1'b0);
    if (wb_we_o) begin
      check("wr_before_done", cfg_done, 1'b0);
      check("wr_expected", exp_wr.size() != 0, 1'b1);
      if (exp_wr.size() != 0) check("cfg_wr", {wb_adr_o, wb_sel_o, wb_dat_o}, exp_wr.pop_front());
    end else begin
      check("rd_after_cfg", cfg_done, 1'b1);
      if (wb_adr_o == 5'd5) begin
        check("lsr_sel", wb_sel_o, 4'b0010);
        wb_dat_i = {16'hA5A5, (rx_q.size() != 0) ? rx_q[0].lsr : 8'h60, 8'hC3};
      end else begin
        check("rbr_adr", wb_adr_o, 5'd0);
        check("rbr_sel", wb_sel_o, 4'b0001);
        check("rbr_has_data", rx_q.size() != 0, 1'b1);
        rbr_t = cyc_n;
        if (rx_q.size() != 0) begin
          wb_dat_i = {16'h5A5A, 8'hFF, rx_q[0].data};
          void'(rx_q.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      wait_cnt = 0;
    end else if (wb_cyc_o && wb_stb_o) begin
      if (wait_cnt == 0) begin
        cap      = {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o};
        unstable = 1'b0;
      end else if (cap !== {wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o}) begin
        unstable = 1'b1;
      end
      if (wait_cnt >= ack_delay) begin
        serve();
        wb_ack_i = 1'b1;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Stream monitor: pops the scoreboard on each handshake and tracks protocol violations.
  int          beats = 0;
  int          viol_dup = 0;
  int          viol_stable = 0;
  int          viol_early = 0;
  int          viol_cyc = 0;
  logic        hs_prev = 1'b0;
  logic        valid_prev = 1'b0;
  logic [11:0] beat_prev = '0;

  always @(negedge clk) begin
    if (hs_prev && m_valid) viol_dup++;
    if (valid_prev && !hs_prev && m_valid && ({m_err, m_data} !== beat_prev)) viol_stable++;
    if (m_valid && !cfg_done) viol_early++;
    if (m_valid && wb_cyc_o) viol_cyc++;
    if (m_valid && !valid_prev) check("valid_latency", cyc_n - rbr_t, 1);
    if (m_valid && m_ready) begin
      beats++;
      check("beat_expected", exp_beats.size() != 0, 1'b1);
      if (exp_beats.size() != 0) check("beat", {m_err, m_data}, exp_beats.pop_front());
    end
    hs_prev    = m_valid && m_ready;
    valid_prev = m_valid;
    beat_prev  = {m_err, m_data};
  end

  task automatic send(input logic [7:0] data, input logic [7:0] lsr);
    rx_q.push_back({lsr, data});
    exp_beats.push_back({lsr[4:1], data});
  endtask

  // Called with reset asserted: checks reset outputs, releases, checks the four config writes.
  task automatic do_config();
    check("reset_outputs", outs(), 64'h0);
    exp_wr.push_back({5'd3, 4'b1000, 32'h9B00_0000});
    exp_wr.push_back({5'd0, 4'b0001, 32'h0000_0002});
    exp_wr.push_back({5'd1, 4'b0010, 32'h0000_0000});
    exp_wr.push_back({5'd3, 4'b1000, 32'h1B00_0000});
    @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    check("first_xfer_cyc", wb_cyc_o, 1'b1);
    for (int i = 0; i < 400 && exp_wr.size() != 0; i++) @(negedge clk);
    check("cfg_writes_left", exp_wr.size(), 0);
    @(negedge clk);
    check("cfg_done", cfg_done, 1'b1);
  endtask

  task automatic wait_beats(input int target, input int budget);
    for (int i = 0; i < budget && beats < target; i++) @(negedge clk);
    check("beat_count", beats, target);
  endtask

  initial begin
    int   drops;
    int   changes;
    int   cyc_seen;
    logic found;

    repeat (3) @(negedge clk);
    do_config();

    // Clean bytes and each LSR error flag, m_ready held high throughout.
    send(8'h81, 8'h61);
    send(8'h42, 8'h61);
    send(8'h5A, 8'h05);
    send(8'h33, 8'h69);
    send(8'hE7, 8'h73);
    wait_beats(5, 800);

    // Backpressure: byte pending for 200 cycles.
    @(posedge clk);
    #1 m_ready = 1'b0;
    send(8'h81, 8'h61);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      found = m_valid;
    end
    check("hold_valid_seen", found, 1'b1);
    drops = 0;
    changes = 0;
    cyc_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!m_valid) drops++;
      if (m_data !== 8'h81) changes++;
      if (wb_cyc_o) cyc_seen++;
    end
    check("hold_drops", drops, 0);
    check("hold_data_changes", changes, 0);
    check("hold_cyc", cyc_seen, 0);
    @(posedge clk);
    #1 m_ready = 1'b1;
    wait_beats(6, 200);

    // Slow slave: seven-cycle ack on every transfer, configuration rerun.
    @(posedge clk);
    #1 wb_rst_i = 1'b1;
    ack_delay = 7;
    #1 check("reset_mid_outputs", outs(), 64'h0);
    do_config();
    send(8'h11, 8'h61);
    send(8'hEE, 8'h63);
    wait_beats(8, 800);

    // Reset while the RBR read is outstanding: byte stays in the UART, config repeats.
    ack_delay = 5;
    send(8'hC7, 8'h61);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      found = wb_cyc_o && !wb_we_o && (wb_adr_o == 5'd0);
    end
    check("rbr_seen", found, 1'b1);
    #1 wb_rst_i = 1'b1;
    #1 check("rst_rbr_cyc", wb_cyc_o, 1'b0);
    check("rst_rbr_valid", m_valid, 1'b0);
    ack_delay = 0;
    repeat (2) @(negedge clk);
    do_config();
    wait_beats(9, 400);

    repeat (20) @(negedge clk);
    check("beats_left", exp_beats.size(), 0);
    check("rx_left", rx_q.size(), 0);
    check("dup_beats", viol_dup, 0);
    check("unstable_beats", viol_stable, 0);
    check("valid_before_cfg", viol_early, 0);
    check("cyc_during_valid", viol_cyc, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
